// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU run/drain/dump sequencer.
// State encodings are fixed so the debug port decodes the same across builds.
package cpu_ctrl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StIdle  = 3'd0;
  localparam state_t StRun   = 3'd1;
  localparam state_t StDrain = 3'd2;
  localparam state_t StShow  = 3'd3;
  localparam state_t StDone  = 3'd4;

  localparam int unsigned DefInstrW   = 32;
  localparam logic [31:0] DefHaltWord = 32'hFFFF_FFFF;

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Control/status bundle between the run sequencer and whoever starts runs
// (bench or board logic). The sequencer side uses the slave modport.
interface cpu_run_ctrl_if #(
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned CNT_W   = 16
);
  logic               start;
  logic [INSTR_W-1:0] instruction;
  logic               run_en;
  logic               show_en;
  logic               done;
  logic               timeout;
  logic [CNT_W-1:0]   cycle_count;
  logic [2:0]         state;

  modport master (
    output start, instruction,
    input  run_en, show_en, done, timeout, cycle_count, state
  );

  modport slave (
    input  start, instruction,
    output run_en, show_en, done, timeout, cycle_count, state
  );
endinterface

// File: rtl/ctrl_down_counter.sv
// Loadable down-counter with a zero flag; used to time the drain and show windows.
module ctrl_down_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/drain/dump sequencer: clock-enables the CPU until halt or cycle budget,
// keeps it clocking to flush the pipeline, then pulses the dump enable.
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned        INSTR_W      = DefInstrW,
  parameter logic [INSTR_W-1:0] HALT_WORD    = DefHaltWord,
  parameter int unsigned        DRAIN_CYCLES = 4,
  parameter int unsigned        SHOW_CYCLES  = 1,
  parameter int unsigned        MAX_CYCLES   = 5001,
  parameter int unsigned        CNT_W        = 16
) (
  input  logic           CLK,
  input  logic           RST,
  cpu_run_ctrl_if.slave  bus
);
  // Down-counters are loaded with N-1 so the zero flag marks the last cycle.
  localparam logic [CNT_W-1:0] MaxLast   = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0] DrainLoad = (DRAIN_CYCLES > 0) ? CNT_W'(DRAIN_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] ShowLoad  = CNT_W'(SHOW_CYCLES - 1);
  localparam bit               HasDrain  = (DRAIN_CYCLES > 0);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
  logic             timeout_q, timeout_d;

  logic drain_load, drain_dec, drain_zero;
  logic show_load, show_dec, show_zero;
  logic halt;

  assign halt = (bus.instruction == HALT_WORD);

  always_comb begin
    state_d       = state_q;
    cycle_count_d = cycle_count_q;
    timeout_d     = timeout_q;
    drain_load    = 1'b0;
    drain_dec     = 1'b0;
    show_load     = 1'b0;
    show_dec      = 1'b0;
    case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          state_d       = StRun;
          cycle_count_d = '0;
          timeout_d     = 1'b0;
        end
      end
      StRun: begin
        if (halt || (cycle_count_q == MaxLast)) begin
          // Halt has priority; the exit edge is never counted.
          timeout_d = !halt;
          if (HasDrain) begin
            state_d    = StDrain;
            drain_load = 1'b1;
          end else begin
            state_d   = StShow;
            show_load = 1'b1;
          end
        end else if (cycle_count_q != '1) begin
          cycle_count_d = cycle_count_q + CNT_W'(1);
        end
      end
      StDrain: begin
        if (drain_zero) begin
          state_d   = StShow;
          show_load = 1'b1;
        end else begin
          drain_dec = 1'b1;
        end
      end
      StShow: begin
        if (show_zero) begin
          state_d = StDone;
        end else begin
          show_dec = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= StIdle;
      cycle_count_q <= '0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cycle_count_q <= cycle_count_d;
      timeout_q     <= timeout_d;
    end
  end

  ctrl_down_counter #(
    .CNT_W (CNT_W)
  ) u_drain_cnt (
    .clk_i      (CLK),
    .rst_i      (RST),
    .load_i     (drain_load),
    .load_val_i (DrainLoad),
    .dec_i      (drain_dec),
    .zero_o     (drain_zero)
  );

  ctrl_down_counter #(
    .CNT_W (CNT_W)
  ) u_show_cnt (
    .clk_i      (CLK),
    .rst_i      (RST),
    .load_i     (show_load),
    .load_val_i (ShowLoad),
    .dec_i      (show_dec),
    .zero_o     (show_zero)
  );

  assign bus.run_en      = (state_q == StRun) || (state_q == StDrain);
  assign bus.show_en     = (state_q == StShow);
  assign bus.done        = (state_q == StDone);
  assign bus.timeout     = timeout_q;
  assign bus.cycle_count = cycle_count_q;
  assign bus.state       = state_q;
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl: three parameterisations, per-cycle expected
// outputs queued at stimulus time and checked on the falling edge.
module tb_cpu_run_ctrl;
  import cpu_ctrl_pkg::*;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  typedef struct {
    int          cyc;
    int          d;
    string       tag;
    logic [22:0] v;
  } exp_t;

  logic clk;
  logic rst_a, rst_b, rst_c;
  int   cyc;
  int   total;
  int   bad;
  exp_t sb[$];

  cpu_run_ctrl_if #(.INSTR_W(32), .CNT_W(16)) ifa ();
  cpu_run_ctrl_if #(.INSTR_W(32), .CNT_W(16)) ifb ();
  cpu_run_ctrl_if #(.INSTR_W(32), .CNT_W(16)) ifc ();

  cpu_run_ctrl #(.MAX_CYCLES(5001)) u_a (.CLK(clk), .RST(rst_a), .bus(ifa));
  cpu_run_ctrl #(.MAX_CYCLES(20))   u_b (.CLK(clk), .RST(rst_b), .bus(ifb));
  cpu_run_ctrl #(
    .MAX_CYCLES   (8),
    .DRAIN_CYCLES (0),
    .SHOW_CYCLES  (3)
  ) u_c (.CLK(clk), .RST(rst_c), .bus(ifc));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [22:0] pk(input bit r, input bit s, input bit dn, input bit to,
                                     input logic [2:0] st, input int c);
    return {r, s, dn, to, st, c[15:0]};
  endfunction

  function automatic logic [22:0] observe(input int d);
    case (d)
      0: return {ifa.run_en, ifa.show_en, ifa.done, ifa.timeout, ifa.state, ifa.cycle_count};
      1: return {ifb.run_en, ifb.show_en, ifb.done, ifb.timeout, ifb.state, ifb.cycle_count};
      default:
        return {ifc.run_en, ifc.show_en, ifc.done, ifc.timeout, ifc.state, ifc.cycle_count};
    endcase
  endfunction

  task automatic drive(input int d, input bit rs, input bit st, input logic [31:0] ins);
    case (d)
      0: begin rst_a = rs; ifa.start = st; ifa.instruction = ins; end
      1: begin rst_b = rs; ifb.start = st; ifb.instruction = ins; end
      default: begin rst_c = rs; ifc.start = st; ifc.instruction = ins; end
    endcase
  endtask

  // Expectation for the cycle following the next rising edge.
  task automatic push(input int d, input string tag, input logic [22:0] v);
    exp_t e;
    e.cyc = cyc + 1;
    e.d   = d;
    e.tag = tag;
    e.v   = v;
    sb.push_back(e);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // One complete run from IDLE/DONE. halt_e: RUN edge (1-based) carrying HALT_WORD,
  // 0 for never. rst_idx >= 0 asserts reset during that DRAIN cycle and stops there.
  task automatic run_seq(input int d, input string tag, input int halt_e, input int maxc,
                         input int drain, input int show, input bit start_run,
                         input bit start_show, input int rst_idx);
    int     cnt;
    bit     to;
    bit     ex;
    bit     h;
    state_t cur;
    state_t st[$];
    drive(d, 0, 1, 32'h0);
    push(d, {tag, "_start"}, pk(1, 0, 0, 0, StRun, 0));
    next();
    cnt = 0;
    to  = 0;
    ex  = 0;
    for (int e = 1; e <= maxc + 1 && !ex; e++) begin
      h = (e == halt_e);
      drive(d, 0, start_run && (e == 2), h ? HALT : 32'(e));
      if (h || cnt == maxc - 1) begin
        ex = 1;
        to = !h;
      end else begin
        cnt++;
        push(d, {tag, "_run"}, pk(1, 0, 0, 0, StRun, cnt));
        next();
      end
    end
    for (int k = 0; k < drain; k++) st.push_back(StDrain);
    for (int k = 0; k < show; k++) st.push_back(StShow);
    st.push_back(StDone);
    st.push_back(StDone);
    for (int i = 0; i < st.size(); i++) begin
      if (i > 0) begin
        cur = st[i-1];
        if (rst_idx >= 0 && cur == StDrain && i - 1 == rst_idx) begin
          drive(d, 1, 0, HALT);
          push(d, {tag, "_rst"}, pk(0, 0, 0, 0, StIdle, 0));
          next();
          drive(d, 0, 0, 32'h0);
          return;
        end
        drive(d, 0, start_show && (cur == StShow), HALT);
      end
      push(d, {tag, "_post"}, pk(st[i] == StDrain, st[i] == StShow, st[i] == StDone, to,
                                 st[i], cnt));
      next();
    end
    drive(d, 0, 0, 32'h0);
  endtask

  // Scoreboard checker.
  initial begin
    exp_t        ce;
    logic [22:0] obs;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        ce  = sb.pop_front();
        obs = observe(ce.d);
        total++;
        assert (ce.cyc == cyc && obs === ce.v)
        else begin
          bad++;
          $error("FAIL %s dut=%0d cyc=%0d observed=%h expected=%h (due cyc %0d)",
                 ce.tag, ce.d, cyc, obs, ce.v, ce.cyc);
        end
      end
    end
  end

  initial begin
    cyc   = 0;
    total = 0;
    bad   = 0;
    for (int d = 0; d < 3; d++) begin
      drive(d, 1, 0, 32'h0);
      push(d, "reset", pk(0, 0, 0, 0, StIdle, 0));
    end
    next();
    for (int d = 0; d < 3; d++) begin
      drive(d, 0, 0, HALT);
      push(d, "idle", pk(0, 0, 0, 0, StIdle, 0));
    end
    next();

    run_seq(0, "s1_halt",     10, 5001, 4, 1, 0, 0, -1);
    run_seq(0, "s6_restart",  10, 5001, 4, 1, 1, 1, -1);
    run_seq(0, "s5_rst",       3, 5001, 4, 1, 0, 0,  1);
    run_seq(0, "s5_fresh",     6, 5001, 4, 1, 0, 0, -1);
    run_seq(1, "s2_timeout",   0,   20, 4, 1, 0, 0, -1);
    run_seq(2, "s3_tie",       8,    8, 0, 3, 0, 0, -1);
    run_seq(2, "s4_nodrain",   4,    8, 0, 3, 0, 1, -1);
    run_seq(2, "s4_timeout",   0,    8, 0, 3, 0, 0, -1);
    run_seq(2, "s4_clear",     2,    8, 0, 3, 0, 0, -1);

    @(negedge clk);
    #1;
    total++;
    assert (sb.size() == 0)
    else begin
      bad++;
      $error("FAIL drain_queue observed=%0d expected=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Synthesisable run/drain/dump sequencer for the single-cycle and pipelined CPU top.
- Gates CPU progress through a clock-enable (run_en).
- Detects the halt sentinel on the fetched instruction, or a cycle-budget timeout.
- Keeps the pipeline clocking for a parametrised drain window, then pulses the register/memory dump enable (show_en).
- Replaces hand-written clock loops in benches and allows on-board halt/dump control.

Parameters:
INSTR_W, 32, instruction word width
HALT_WORD, 32'hFFFF_FFFF, sentinel instruction that ends a run (INSTR_W bits)
DRAIN_CYCLES, 4, cycles run_en stays high after halt to flush the pipeline; 0 allowed
SHOW_CYCLES, 1, cycles show_en is held high; minimum 1
MAX_CYCLES, 5001, RUN-phase cycle budget before forced timeout; minimum 1
CNT_W, 16, width of cycle_count and internal counters; must hold MAX_CYCLES, DRAIN_CYCLES and SHOW_CYCLES

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  synchronous, active-high reset
start  in  1  begin a run; sampled only in IDLE or DONE
instruction  in  INSTR_W  instruction currently fetched by the CPU
run_en  out  1  CPU clock enable
show_en  out  1  dump enable to CPU register file / data memory
done  out  1  high while in DONE
timeout  out  1  sticky; run ended by MAX_CYCLES, not by HALT_WORD
cycle_count  out  CNT_W  RUN-phase cycles executed in the current or last run
state  out  3  encoded FSM state, for debug

Behaviour:
- Reset: RST high at a CLK edge puts the FSM in IDLE. run_en=0, show_en=0, done=0, timeout=0, cycle_count=0, drain/show counters=0. Applies from any state, including mid-RUN and mid-DRAIN.
- States and encodings: IDLE=0, RUN=1, DRAIN=2, SHOW=3, DONE=4. All outputs are registered or decoded from state; no combinational path from instruction to any output.
- IDLE: all outputs 0. start=1 → RUN on the next edge; cycle_count and timeout cleared.
- RUN: run_en=1.
  - Each edge in RUN with no exit: cycle_count += 1, saturating at all-ones.
  - Halt: instruction==HALT_WORD at an edge → exit. The halt cycle is not counted.
  - Timeout: cycle_count==MAX_CYCLES-1 at an edge with no halt → exit, timeout←1.
  - Exit goes to DRAIN if DRAIN_CYCLES>0, else to SHOW.
  - Halt and timeout on the same edge: halt wins, timeout stays 0.
- DRAIN: run_en=1 for exactly DRAIN_CYCLES cycles (down-counter loaded on entry), then SHOW. instruction is ignored; a repeated HALT_WORD has no effect.
- SHOW: run_en=0, show_en=1 for exactly SHOW_CYCLES cycles, then DONE.
- DONE: run_en=0, show_en=0, done=1. cycle_count and timeout are held. start=1 → RUN: cycle_count cleared, timeout cleared, done drops on the same edge.
- start: ignored in RUN, DRAIN and SHOW; it is not queued.
- Latency, start edge to first run_en=1 cycle: 1 clock.
- Latency, halt edge to first show_en=1 cycle: DRAIN_CYCLES+1 clocks.
- Counters compare at full CNT_W width; parameters are zero-extended.

Decomposition:
- Shared package cpu_ctrl_pkg:
  - state enum localparams (IDLE..DONE, 3-bit).
  - default HALT_WORD.
  - default INSTR_W.
- One natural sub-module, ctrl_down_counter: loadable CNT_W down-counter with a zero flag. Instantiated twice, once for DRAIN and once for SHOW.
- The RUN up-counter stays inline because it saturates.

Test Plan:
1. Normal halt. Defaults; start at cycle 0; instruction=HALT_WORD on the 10th RUN edge → cycle_count=9; run_en high for exactly 9+1+4 cycles; show_en high for exactly 1 cycle, 5 clocks after the halt edge; then done=1, timeout=0.
2. Timeout. MAX_CYCLES=20; instruction never equals HALT_WORD → cycle_count=19, timeout=1, drain of 4 cycles, show_en pulse, done=1.
3. Simultaneous halt and timeout. MAX_CYCLES=8; HALT_WORD presented on the edge where cycle_count==7 → timeout=0, cycle_count=7.
4. No drain, wide show. DRAIN_CYCLES=0, SHOW_CYCLES=3 → show_en high on the edge immediately after halt, for 3 cycles; run_en=0 throughout SHOW.
5. Reset mid-operation. RST asserted in the 2nd DRAIN cycle → next edge: state=0, all outputs 0; start then yields a fresh run with cycle_count counting from 0.
6. Restart and start masking. start pulsed during RUN and during SHOW → no effect; start in DONE → RUN next edge, done=0, cycle_count=0, timeout=0; a second halt run reproduces scenario 1 timing.
